// File: rtl/branch_target_queue_if.sv
// Decoder-to-queue-to-branch-unit bus for the branch target queue.
// slave is the queue's view, master is the environment's (decoder and branch unit) view.
interface branch_target_queue_if #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int opcodeSize              = 12,
    parameter int bodyWidth               = 28
);
    // decoder side
    logic                               enable_i;
    logic [opcodeSize-1:0]              opcode_i;
    logic [0:bodyWidth-1]               instructionBody_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic                               is64Bit_i;
    logic [instructionCounterWidth-1:0] instMajId_i;
    logic [instMinIdWidth-1:0]          instMinId_i;
    logic [PidSize-1:0]                 instPid_i;
    logic [TidSize-1:0]                 instTid_i;
    logic                               stall_o;
    logic                               dropped_o;
    // branch unit side
    logic                               ready_i;
    logic                               valid_o;
    logic [addressWidth-1:0]            target_o;
    logic [addressWidth-1:0]            linkAddr_o;
    logic [0:4]                         BO_o;
    logic [0:4]                         BI_o;
    logic                               usesCtr_o;
    logic                               writesLr_o;
    logic                               unconditional_o;
    logic [instructionCounterWidth-1:0] majId_o;
    logic [instMinIdWidth-1:0]          minId_o;
    logic [PidSize-1:0]                 pid_o;
    logic [TidSize-1:0]                 tid_o;

    modport slave (
        input  enable_i, opcode_i, instructionBody_i, instructionAddress_i, is64Bit_i,
               instMajId_i, instMinId_i, instPid_i, instTid_i, ready_i,
        output stall_o, dropped_o, valid_o, target_o, linkAddr_o, BO_o, BI_o,
               usesCtr_o, writesLr_o, unconditional_o, majId_o, minId_o, pid_o, tid_o
    );

    modport master (
        output enable_i, opcode_i, instructionBody_i, instructionAddress_i, is64Bit_i,
               instMajId_i, instMinId_i, instPid_i, instTid_i, ready_i,
        input  stall_o, dropped_o, valid_o, target_o, linkAddr_o, BO_o, BI_o,
               usesCtr_o, writesLr_o, unconditional_o, majId_o, minId_o, pid_o, tid_o
    );
endinterface

// File: rtl/branch_target_queue.sv
// Branch target queue: resolves B-form Branch Conditional targets/link addresses
// on the input side and buffers them in a DEPTH-entry FIFO for branch dispatch.
module branch_target_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int opcodeSize              = 12,
    parameter int bodyWidth               = 28,
    parameter int DEPTH                   = 4,
    parameter int BranchCondOpcode        = 25
) (
    input logic clock_i,
    input logic reset_i,
    branch_target_queue_if.slave bus
);
    localparam int PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FULL = (PtrW + 1)'(DEPTH);
    localparam logic [addressWidth-1:0] LOW32_MASK = addressWidth'(64'h0000_0000_FFFF_FFFF);

    typedef struct packed {
        logic [addressWidth-1:0]            target;
        logic [addressWidth-1:0]            link;
        logic [0:4]                         bo;
        logic [0:4]                         bi;
        logic                               uses_ctr;
        logic                               writes_lr;
        logic                               uncond;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [instMinIdWidth-1:0]          min_id;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
    } entry_t;

    entry_t              mem [DEPTH];
    entry_t              in_entry;
    entry_t              head;
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic [PtrW:0]       count;
    logic                valid;
    logic                pop;
    logic                accept;
    logic                push;
    logic                drop;
    logic                dropped_q;
    logic [0:13]         bd;
    logic                aa;
    logic [addressWidth-1:0] disp;
    logic [addressWidth-1:0] target_raw;
    logic [addressWidth-1:0] link_raw;
    logic [1:0]          unused_pad;

    // Handshake: stall only when full and no pop frees a slot this cycle.
    always_comb begin
        valid       = (count != '0);
        pop         = valid && bus.ready_i;
        bus.stall_o = (count == FULL) && !pop;
        accept      = bus.enable_i && !bus.stall_o;
        push        = accept && (bus.opcode_i == opcodeSize'(BranchCondOpcode));
        drop        = accept && (bus.opcode_i != opcodeSize'(BranchCondOpcode));
    end

    // Decode the body and resolve target/link/flags for the incoming instruction.
    always_comb begin
        bd         = bus.instructionBody_i[10:23];
        aa         = bus.instructionBody_i[26];
        unused_pad = bus.instructionBody_i[24:25];
        disp       = {{(addressWidth - 16){bd[0]}}, bd, 2'b00};
        target_raw = aa ? disp : bus.instructionAddress_i + disp;
        link_raw   = bus.instructionAddress_i + addressWidth'(4);
        in_entry           = '0;
        in_entry.target    = bus.is64Bit_i ? target_raw : (target_raw & LOW32_MASK);
        in_entry.link      = bus.is64Bit_i ? link_raw : (link_raw & LOW32_MASK);
        in_entry.bo        = bus.instructionBody_i[0:4];
        in_entry.bi        = bus.instructionBody_i[5:9];
        in_entry.uses_ctr  = ~bus.instructionBody_i[2];
        in_entry.writes_lr = bus.instructionBody_i[27];
        in_entry.uncond    = bus.instructionBody_i[0] & bus.instructionBody_i[2];
        in_entry.maj_id    = bus.instMajId_i;
        in_entry.min_id    = bus.instMinId_i;
        in_entry.pid       = bus.instPid_i;
        in_entry.tid       = bus.instTid_i;
    end

    // Pointer, occupancy and drop-pulse state.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dropped_q <= 1'b0;
        end else begin
            dropped_q <= drop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Outputs come straight from the head entry registers.
    always_comb begin
        head                = mem[rd_ptr];
        bus.valid_o         = valid;
        bus.dropped_o       = dropped_q;
        bus.target_o        = head.target;
        bus.linkAddr_o      = head.link;
        bus.BO_o            = head.bo;
        bus.BI_o            = head.bi;
        bus.usesCtr_o       = head.uses_ctr;
        bus.writesLr_o      = head.writes_lr;
        bus.unconditional_o = head.uncond;
        bus.majId_o         = head.maj_id;
        bus.minId_o         = head.min_id;
        bus.pid_o           = head.pid;
        bus.tid_o           = head.tid;
    end
endmodule

// File: tb/tb_branch_target_queue.sv
// Scoreboard bench for branch_target_queue: directed vectors push expected
// entries on acceptance, an independent monitor checks every pop.
module tb_branch_target_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_target_queue_if bus ();
    branch_target_queue dut (.clock_i(clk), .reset_i(rst_n), .bus(bus.slave));

    typedef struct {
        logic [63:0] target;
        logic [63:0] link;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic        uc;
        logic        lr;
        logic        un;
        logic [63:0] id;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic exp_t mk_exp(input logic [63:0] t, input logic [63:0] l, input logic [4:0] bo,
                                    input logic [4:0] bi, input logic uc, input logic lr,
                                    input logic un, input logic [63:0] id);
        exp_t e;
        e.target = t; e.link = l; e.bo = bo; e.bi = bi;
        e.uc = uc; e.lr = lr; e.un = un; e.id = id;
        return e;
    endfunction

    // Drive one decoder output; IDs are derived from id so the monitor can check them.
    task automatic drive(input logic [63:0] addr, input logic [4:0] bo, input logic [4:0] bi,
                         input logic [13:0] bd, input logic aa, input logic lk,
                         input logic is64, input logic [11:0] opc, input logic [63:0] id);
        bus.enable_i             = 1'b1;
        bus.opcode_i             = opc;
        bus.instructionBody_i    = {bo, bi, bd, 2'b00, aa, lk};
        bus.instructionAddress_i = addr;
        bus.is64Bit_i            = is64;
        bus.instMajId_i          = id;
        bus.instMinId_i          = id[6:0];
        bus.instPid_i            = 20'(id + 64'h100);
        bus.instTid_i            = 16'(id + 64'h20);
    endtask

    // Hold the input until it is accepted (stall_o low), like the decoder does.
    task automatic send(input logic [63:0] addr, input logic [4:0] bo, input logic [4:0] bi,
                        input logic [13:0] bd, input logic aa, input logic lk,
                        input logic is64, input logic [11:0] opc, input logic [63:0] id,
                        input exp_t e, input bit expect_push);
        bit done = 0;
        drive(addr, bo, bi, bd, aa, lk, is64, opc, id);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!bus.stall_o) begin
                if (expect_push) sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd1, 64'd0);
        bus.enable_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        #1;
        chk("drain_valid", 64'(bus.valid_o), 64'd0);
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop: got majId 0x%0h expected no entry", bus.majId_o);
                end else begin
                    e = sb.pop_front();
                    chk("target",  bus.target_o,   e.target);
                    chk("link",    bus.linkAddr_o, e.link);
                    chk("BO",      64'(bus.BO_o),  64'(e.bo));
                    chk("BI",      64'(bus.BI_o),  64'(e.bi));
                    chk("usesCtr", 64'(bus.usesCtr_o), 64'(e.uc));
                    chk("writesLr", 64'(bus.writesLr_o), 64'(e.lr));
                    chk("uncond",  64'(bus.unconditional_o), 64'(e.un));
                    chk("majId",   bus.majId_o, e.id);
                    chk("minId",   64'(bus.minId_o), 64'(e.id[6:0]));
                    chk("pid",     64'(bus.pid_o), 64'(20'(e.id + 64'h100)));
                    chk("tid",     64'(bus.tid_o), 64'(16'(e.id + 64'h20)));
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.ready_i = 1'b0;
        drive(64'h0, 5'd0, 5'd0, 14'd0, 1'b0, 1'b0, 1'b1, 12'd0, 64'd0);
        bus.enable_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid",   64'(bus.valid_o), 64'd0);
        chk("rst_stall",   64'(bus.stall_o), 64'd0);
        chk("rst_dropped", 64'(bus.dropped_o), 64'd0);
        chk("rst_target",  bus.target_o, 64'd0);
        chk("rst_link",    bus.linkAddr_o, 64'd0);
        chk("rst_majId",   bus.majId_o, 64'd0);

        // Relative negative displacement, latency of one cycle
        bus.ready_i = 1'b1;
        e = mk_exp(64'hFFC, 64'h1004, 5'b10100, 5'd3, 1'b0, 1'b1, 1'b1, 64'd1);
        send(64'h1000, 5'b10100, 5'd3, 14'h3FFF, 1'b0, 1'b1, 1'b1, 12'd25, 64'd1, e, 1);
        chk("latency_valid", 64'(bus.valid_o), 64'd1);

        // Absolute positive and absolute negative
        e = mk_exp(64'h40, 64'h8000_0000_0000_0004, 5'b00000, 5'd0, 1'b1, 1'b0, 1'b0, 64'd2);
        send(64'h8000_0000_0000_0000, 5'b00000, 5'd0, 14'h0010, 1'b1, 1'b0, 1'b1, 12'd25, 64'd2, e, 1);
        e = mk_exp(64'hFFFF_FFFF_FFFF_8000, 64'h104, 5'b00100, 5'd31, 1'b0, 1'b1, 1'b0, 64'd3);
        send(64'h100, 5'b00100, 5'd31, 14'h2000, 1'b1, 1'b1, 1'b1, 12'd25, 64'd3, e, 1);

        // 32-bit mode wrap
        e = mk_exp(64'h4, 64'h0, 5'b10100, 5'd2, 1'b0, 1'b0, 1'b1, 64'd4);
        send(64'hFFFF_FFFC, 5'b10100, 5'd2, 14'd2, 1'b0, 1'b0, 1'b0, 12'd25, 64'd4, e, 1);
        drain();

        // Invalid opcode is dropped
        send(64'h3000, 5'b10100, 5'd1, 14'd1, 1'b0, 1'b0, 1'b1, 12'd0, 64'd99, e, 0);
        chk("drop_pulse", 64'(bus.dropped_o), 64'd1);
        chk("drop_novalid", 64'(bus.valid_o), 64'd0);
        @(posedge clk);
        #1;
        chk("drop_pulse_end", 64'(bus.dropped_o), 64'd0);
        chk("drop_still_empty", 64'(bus.valid_o), 64'd0);

        // Back-pressure: four fill the queue, fifth is held
        bus.ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            e = mk_exp(64'h2000 + 64'(i) * 64'h100 + 64'h4, 64'h2000 + 64'(i) * 64'h100 + 64'h4,
                       5'b10100, 5'd0, 1'b0, 1'b0, 1'b1, 64'(i) + 64'd10);
            send(64'h2000 + 64'(i) * 64'h100, 5'b10100, 5'd0, 14'd1, 1'b0, 1'b0, 1'b1, 12'd25,
                 64'(i) + 64'd10, e, 1);
        end
        e = mk_exp(64'h2504, 64'h2504, 5'b10100, 5'd0, 1'b0, 1'b0, 1'b1, 64'd15);
        drive(64'h2500, 5'b10100, 5'd0, 14'd1, 1'b0, 1'b0, 1'b1, 12'd25, 64'd15);
        @(negedge clk);
        chk("bp_stall_full", 64'(bus.stall_o), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_stall_hold", 64'(bus.stall_o), 64'd1);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        chk("bp_stall_pop", 64'(bus.stall_o), 64'd0);
        @(posedge clk);
        #1;
        bus.ready_i  = 1'b0;
        bus.enable_i = 1'b0;
        @(negedge clk);
        chk("bp_still_full", 64'(bus.stall_o), 64'd1);
        chk("bp_valid", 64'(bus.valid_o), 64'd1);
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        drain();

        // Reset with three entries queued; input during reset is ignored
        bus.ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            e = mk_exp(64'h5004, 64'h5004, 5'b10100, 5'd0, 1'b0, 1'b0, 1'b1, 64'(i) + 64'd20);
            send(64'h5000, 5'b10100, 5'd0, 14'd1, 1'b0, 1'b0, 1'b1, 12'd25, 64'(i) + 64'd20, e, 1);
        end
        rst_n = 1'b0;
        drive(64'h6000, 5'b10100, 5'd0, 14'd1, 1'b0, 1'b1, 1'b1, 12'd25, 64'd30);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.enable_i = 1'b0;
        chk("mrst_valid",  64'(bus.valid_o), 64'd0);
        chk("mrst_stall",  64'(bus.stall_o), 64'd0);
        chk("mrst_target", bus.target_o, 64'd0);
        chk("mrst_link",   bus.linkAddr_o, 64'd0);
        chk("mrst_lr",     64'(bus.writesLr_o), 64'd0);
        chk("mrst_majId",  bus.majId_o, 64'd0);
        bus.ready_i = 1'b1;
        e = mk_exp(64'h7008, 64'h7004, 5'b00100, 5'd7, 1'b0, 1'b1, 1'b0, 64'd31);
        send(64'h7000, 5'b00100, 5'd7, 14'd2, 1'b0, 1'b1, 1'b1, 12'd25, 64'd31, e, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_target_queue.md
# branch_target_queue

Sits directly downstream of the B-format decoder and consumes its decoded Branch Conditional output. For each instruction it resolves the branch target and link address, and classifies CTR/LR usage. Results are buffered in a DEPTH-entry FIFO that feeds the branch unit dispatch. Back-pressure is returned to the decoder through its stall input.

## Interface
Parameters:
- addressWidth, 64, instruction/target address width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- opcodeSize, 12, decoded opcode width
- bodyWidth, 28, decoded B body width (BO 5, BI 5, BD 14, pad 2, AA, LK)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- BranchCondOpcode, 25, the only decoded opcode accepted

Ports:
- clock_i  in  1  single clock, all state on posedge
- reset_i  in  1  synchronous, active-low (0 = reset, sampled on posedge)
- enable_i  in  1  decoded instruction valid (decoder enable_o)
- opcode_i  in  opcodeSize  decoded opcode
- instructionBody_i  in  [0:bodyWidth-1]  MSB-first: [0:4] BO, [5:9] BI, [10:23] BD, [24:25] 00, [26] AA, [27] LK
- instructionAddress_i  in  addressWidth  branch instruction address
- is64Bit_i  in  1  64-bit mode
- instMajId_i  in  instructionCounterWidth  major ID
- instMinId_i  in  instMinIdWidth  minor ID
- instPid_i  in  PidSize  process ID
- instTid_i  in  TidSize  thread ID
- ready_i  in  1  branch unit accepts head entry
- stall_o  out  1  combinational; drives the decoder stall_i
- valid_o  out  1  head entry valid
- target_o  out  addressWidth  resolved branch target
- linkAddr_o  out  addressWidth  address + 4
- BO_o  out  5  branch options
- BI_o  out  5  CR bit select (BI+32 at use)
- usesCtr_o  out  1  BO[2]==0
- writesLr_o  out  1  LK
- unconditional_o  out  1  BO[0]&BO[2]
- majId_o, minId_o, pid_o, tid_o  out  matching widths  passthrough of the head entry
- dropped_o  out  1  one-cycle pulse when an input is discarded

## Operation
- Push condition: enable_i && !stall_o && opcode_i==BranchCondOpcode.
- Drop condition: enable_i && !stall_o && opcode_i!=BranchCondOpcode. The input is consumed and not stored; dropped_o pulses in the next cycle.
- Pop condition: valid_o && ready_i.
- stall_o = (count==DEPTH) && !pop. It is combinational, so the decoder advances exactly in cycles where stall_o is low. Each input is consumed once even though the decoder holds its output while stalled.
- disp = sign-extend to addressWidth of {BD, 2'b00}, a 16-bit two's-complement value.
- target = AA ? disp : instructionAddress_i + disp, modulo 2^addressWidth.
- linkAddr = instructionAddress_i + 4, modulo 2^addressWidth.
- When is64Bit_i==0, bits [0:31] of target and linkAddr are forced to 0. This applies after the add, so it also covers the AA=1 case.
- Target, link and flags are computed on the input side and stored per entry. Outputs come directly from the head entry registers; there is no combinational path from inputs to data outputs.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count has log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged. Allowed when full, because stall_o is low in that cycle.
- Pop when empty cannot occur, since valid_o=0.

## Timing
- Reset (reset_i==0 at posedge): count, pointers, valid_o and dropped_o are 0. All data outputs are 0. stall_o is 0 afterwards.
- Reset mid-operation: all queued entries are discarded. The input sampled in the reset cycle is ignored.
- Latency: an instruction pushed at edge N into an empty queue gives valid_o=1 with its fields after edge N.
- Throughput: one push and one pop per cycle.
- Head data is stable while valid_o && !ready_i.
- Order is strictly FIFO (major ID order as received).

## Test plan
- Relative negative: addr 0x1000, BD=0x3FFF, AA=0, LK=1, BO=0b10100, 64-bit. Expect target 0xFFC, linkAddr 0x1004, writesLr_o=1, usesCtr_o=0, unconditional_o=1, with valid_o one cycle after the push.
- Absolute: BD=0x0010, AA=1, addr 0x8000_0000_0000_0000. Expect target 0x40. Then BD=0x2000, AA=1: expect target 0xFFFF_FFFF_FFFF_8000.
- 32-bit wrap: is64Bit_i=0, addr 0xFFFF_FFFC, BD=2, AA=0. Expect target 0x4 and linkAddr 0x0.
- Back-pressure: ready_i=0, five consecutive enables. stall_o rises after the 4th push and the 5th input is held. Then ready_i=1 for one cycle: expect a pop and a push in the same cycle, count stays 4, the 5th entry is stored exactly once, and IDs come out in order 1..5.
- Invalid opcode: opcode_i=0 with enable_i. Expect dropped_o pulse, no valid_o, count unchanged.
- Reset with 3 entries queued: reset_i=0 for one cycle. Expect valid_o=0, stall_o=0 and all outputs 0. A subsequent push appears as the head.
